// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift_frame_ctrl serial framing sequencer.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } frame_state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_frame_ctrl_counter.sv
// frame_bit_counter: counts accepted data bits of the current frame.
// terminal flags the strobe that carries the last data bit.
module frame_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  // Bit counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign terminal = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: frames a serial stream into WIDTH-bit words via an external
// shift_register and hands them off on valid/ready. Optional macro: PARITY_CHECK_EN.
module shift_frame_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             sr_reset_n,
  output logic             sr_shift_en,
  output logic             sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             parity_err,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy
);

  frame_state_e state;
  frame_state_e state_next;
  logic         clr;
  logic         shift_acc;
  logic         terminal;
  logic         ovf_set;

  // In HOLD a new frame may only start together with the handshake.
  assign clr         = frame_start & ((state != HOLD) | m_ready);
  assign shift_acc   = ser_valid & (state == SHIFT) & ~clr;
  assign ovf_set     = ser_valid & (state == HOLD) & ~clr;

  assign sr_reset_n  = ~(reset | clr);
  assign sr_data_in  = ser_data;
  assign sr_shift_en = shift_acc;
  assign m_data      = sr_data_out;
  assign m_valid     = (state == HOLD);
  assign busy        = (state != IDLE);

  frame_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .inc      (shift_acc),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clr) state_next = SHIFT;
        else     state_next = IDLE;
      end
      SHIFT: begin
        if (clr) begin
          state_next = SHIFT;
        end else if (shift_acc && terminal) begin
`ifdef PARITY_CHECK_EN
          state_next = PARITY;
`else
          state_next = HOLD;
`endif
        end else begin
          state_next = SHIFT;
        end
      end
      PARITY: begin
        if (clr)            state_next = SHIFT;
        else if (ser_valid) state_next = HOLD;
        else                state_next = PARITY;
      end
      HOLD: begin
        if (m_ready) state_next = frame_start ? SHIFT : IDLE;
        else         state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky overflow; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

`ifdef PARITY_CHECK_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Parity verdict captured with the parity strobe, dropped when the word leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if ((state == PARITY) && ser_valid && !clr) begin
      parity_err <= even_parity(sr_data_out) ^ ser_data;
    end else if ((state == HOLD) && m_ready) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench for shift_frame_ctrl paired with a behavioural shift register.
module tb_shift_frame_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1, frame_start = 1'b0, ser_valid = 1'b0, ser_data = 1'b0;
  logic m_ready = 1'b0, ovf_clr = 1'b0;
  logic sr_reset_n, sr_shift_en, sr_data_in, m_valid, parity_err, overflow, busy;
  logic [W-1:0] sr_data_out, m_data;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic ok;

  always #5 clk = ~clk;

  // Behavioural serial-in/parallel-out register, MSB first.
  always_ff @(posedge clk) begin
    if (!sr_reset_n) sr_data_out <= '0;
    else if (sr_shift_en) sr_data_out <= {sr_data_out[W-2:0], sr_data_in};
  end

  shift_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .ser_valid(ser_valid),
    .ser_data(ser_data), .sr_reset_n(sr_reset_n), .sr_shift_en(sr_shift_en),
    .sr_data_in(sr_data_in), .sr_data_out(sr_data_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .parity_err(parity_err),
    .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
  );

  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'b1;
      ser_data  = w[W-1-i];
      @(negedge clk);
    end
    ser_valid = 1'b0;
  endtask

  task automatic send_par(input logic b);
`ifdef PARITY_CHECK_EN
    ser_valid = 1'b1;
    ser_data  = b;
    @(negedge clk);
    ser_valid = 1'b0;
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic pbit);
    start_frame();
    send_bits(w, W);
    send_par(pbit);
  endtask

  task automatic wait_valid(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, m_valid, overflow, parity_err, sr_reset_n} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_state got busy/valid/ovf/perr/srn=%b exp=00000",
               {busy, m_valid, overflow, parity_err, sr_reset_n});
    end
    reset = 1'b0;
    #1;
    total++;
    if (sr_reset_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_release sr_reset_n got=%b exp=1", sr_reset_n);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    exp_q.push_back(8'hB2);
    send_word(8'hB2, 1'b0);
    wait_valid(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%b exp=1", ok); end
    exp_w = exp_q.pop_front();
    total++;
    if (m_data !== exp_w || parity_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_data got=%h perr=%b exp=%h perr=0", m_data, parity_err, exp_w);
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got valid=%b busy=%b exp 0 0", m_valid, busy);
    end
    ser_valid = 1'b1;
    #1;
    total++;
    if (sr_shift_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_shift_en got=%b exp=0", sr_shift_en);
    end
    repeat (2) @(negedge clk);
    ser_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignore got busy=%b ovf=%b exp 0 0", busy, overflow);
    end
  endtask

  task automatic test_hold_overflow();
    m_ready = 1'b0;
    exp_q.push_back(8'hB2);
    send_word(8'hB2, 1'b0);
    wait_valid(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL hold_timeout got=%b exp=1", ok); end
    for (int c = 0; c < 5; c++) begin
      ser_valid = (c == 1 || c == 3);
      ser_data  = 1'b1;
      @(negedge clk);
      ser_valid = 1'b0;
      total++;
      if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
        bad++;
        $display("FAIL hold_cycle%0d got valid=%b data=%h exp 1 %h", c, m_valid, m_data, exp_q[0]);
      end
    end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    ovf_clr = 1'b1;
    ser_valid = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    @(negedge clk);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    m_ready = 1'b1;
    exp_w = exp_q.pop_front();
    total++;
    if (m_data !== exp_w) begin bad++; $display("FAIL hold_data got=%h exp=%h", m_data, exp_w); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold_release busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    m_ready = 1'b1;
    start_frame();
    send_bits(8'hF0, 4);
    frame_start = 1'b1;
    ser_valid   = 1'b1;
    ser_data    = 1'b1;
    #1;
    total++;
    if (sr_shift_en !== 1'b0 || sr_reset_n !== 1'b0) begin
      bad++;
      $display("FAIL abort_clr got shift_en=%b srn=%b exp 0 0", sr_shift_en, sr_reset_n);
    end
    @(negedge clk);
    frame_start = 1'b0;
    ser_valid   = 1'b0;
    total++;
    if (busy !== 1'b1 || sr_data_out !== 8'h00) begin
      bad++;
      $display("FAIL abort_restart got busy=%b sr=%h exp 1 00", busy, sr_data_out);
    end
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, W);
    send_par(1'b0);
    wait_valid(ok);
    exp_w = exp_q.pop_front();
    total++;
    if (ok !== 1'b1 || m_data !== exp_w || overflow !== 1'b0) begin
      bad++;
      $display("FAIL abort_data got ok=%b data=%h ovf=%b exp 1 %h 0", ok, m_data, overflow, exp_w);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'h0F);
    send_word(8'hB2, 1'b0);
    wait_valid(ok);
    exp_w = exp_q.pop_front();
    total++;
    if (ok !== 1'b1 || m_data !== exp_w) begin
      bad++;
      $display("FAIL b2b_first got ok=%b data=%h exp 1 %h", ok, m_data, exp_w);
    end
    m_ready     = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++;
    if (busy !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_idle got busy=%b valid=%b exp 1 0", busy, m_valid);
    end
    send_bits(8'h0F, W);
    send_par(1'b0);
    exp_w = exp_q.pop_front();
    total++;
    if (m_valid !== 1'b1 || m_data !== exp_w) begin
      bad++;
      $display("FAIL b2b_second got valid=%b data=%h exp 1 %h", m_valid, m_data, exp_w);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_end busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    start_frame();
    send_bits(8'hE0, 3);
    reset = 1'b1;
    #1;
    total++;
    if (sr_reset_n !== 1'b0) begin bad++; $display("FAIL midrst_srn got=%b exp=0", sr_reset_n); end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state got valid=%b busy=%b exp 0 0", m_valid, busy);
    end
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 1'b0);
    wait_valid(ok);
    exp_w = exp_q.pop_front();
    total++;
    if (ok !== 1'b1 || m_data !== exp_w) begin
      bad++;
      $display("FAIL midrst_data got ok=%b data=%h exp 1 %h", ok, m_data, exp_w);
    end
    @(negedge clk);
  endtask

  task automatic test_parity();
`ifdef PARITY_CHECK_EN
    m_ready = 1'b0;
    start_frame();
    send_bits(8'hB2, W);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL par_wait valid got=%b exp=0", m_valid); end
    send_par(1'b0);
    total++;
    if (m_valid !== 1'b1 || parity_err !== 1'b0) begin
      bad++;
      $display("FAIL par_good got valid=%b perr=%b exp 1 0", m_valid, parity_err);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_q.push_back(8'hB2);
    send_word(8'hB2, 1'b1);
    exp_w = exp_q.pop_front();
    total++;
    if (m_valid !== 1'b1 || parity_err !== 1'b1 || m_data !== exp_w) begin
      bad++;
      $display("FAIL par_bad got valid=%b perr=%b data=%h exp 1 1 %h", m_valid, parity_err, m_data, exp_w);
    end
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clear got=%b exp=0", parity_err); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
